// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C master arbiter: FSM states and pointer sizing.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    COMPLETE
  } arb_state_t;

  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Command/response bundle between the arbiter (master modport) and the
// single I2C master controller (slave modport).
interface i2c_master_arbiter_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] m_address;
  logic                  m_rw;
  logic [DATA_WIDTH-1:0] m_data_in;
  logic                  m_enable;
  logic [DATA_WIDTH-1:0] m_data_out;
  logic                  m_ready;

  modport master (
    output m_address, m_rw, m_data_in, m_enable,
    input  m_data_out, m_ready
  );

  modport slave (
    input  m_address, m_rw, m_data_in, m_enable,
    output m_data_out, m_ready
  );
endinterface

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping.
module i2c_rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] idx
);
  int            j;
  logic [PW-1:0] js;

  // Scan farthest-first so the nearest set bit overwrites last.
  always_comb begin
    win = '0;
    idx = '0;
    j   = 0;
    js  = '0;
    for (int i = N; i >= 1; i--) begin
      j  = (int'(ptr) + i) % N;
      js = PW'(j);
      if (req[js]) begin
        win     = '0;
        win[js] = 1'b1;
        idx     = js;
      end
    end
  end
endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin share of one I2C master among NUM_REQ clients.
// Optional per-transaction abort: define I2C_MASTER_ARBITER_TIMEOUT_EN.
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_rw,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          busy,
  i2c_master_arbiter_if.master          m
);
  import i2c_arb_pkg::*;

  localparam int PW = ptr_width(NUM_REQ);

  arb_state_t            state, state_n;
  logic [PW-1:0]         rr_ptr, ptr_n, win_idx;
  logic [NUM_REQ-1:0]    win, grant_n, done_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] wd_q, wd_n, rdata_n;
  logic                  rw_q, rw_n;
  logic                  en_q, en_n;
  logic                  err_n, rdy_q, to_hit;

  i2c_rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .win (win),
    .idx (win_idx)
  );

`ifdef I2C_MASTER_ARBITER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt <= '0;
    else if (state == LAUNCH) tcnt <= '0;
    else if (state inside {WAIT_BUSY, WAIT_DONE}) tcnt <= tcnt + 1'b1;
  end

  assign to_hit = (state inside {WAIT_BUSY, WAIT_DONE}) &&
                  (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    ptr_n   = rr_ptr;
    grant_n = grant;
    done_n  = '0;
    addr_n  = addr_q;
    rw_n    = rw_q;
    wd_n    = wd_q;
    en_n    = en_q;
    err_n   = err;
    rdata_n = rdata;
    unique case (state)
      IDLE: begin
        if ((|req) && rdy_q) begin
          grant_n = win;
          addr_n  = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          rw_n    = req_rw[win_idx];
          wd_n    = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
          ptr_n   = win_idx;
          state_n = LAUNCH;
        end
      end
      LAUNCH: begin
        en_n    = 1'b1;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (to_hit) begin
          en_n    = 1'b0;
          err_n   = 1'b1;
          done_n  = grant;
          state_n = COMPLETE;
        end else if (!rdy_q) begin
          en_n    = 1'b0;
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (to_hit) begin
          en_n    = 1'b0;
          err_n   = 1'b1;
          done_n  = grant;
          state_n = COMPLETE;
        end else if (rdy_q) begin
          if (rw_q) rdata_n = m.m_data_out;
          err_n   = 1'b0;
          done_n  = grant;
          state_n = COMPLETE;
        end
      end
      COMPLETE: begin
        grant_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Pointer resets to the last client so client 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= PW'(NUM_REQ - 1);
      grant  <= '0;
      done   <= '0;
      addr_q <= '0;
      rw_q   <= 1'b0;
      wd_q   <= '0;
      en_q   <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
      rdy_q  <= 1'b1;
    end else begin
      state  <= state_n;
      rr_ptr <= ptr_n;
      grant  <= grant_n;
      done   <= done_n;
      addr_q <= addr_n;
      rw_q   <= rw_n;
      wd_q   <= wd_n;
      en_q   <= en_n;
      err    <= err_n;
      rdata  <= rdata_n;
      rdy_q  <= m.m_ready;
    end
  end

  assign busy        = (state != IDLE);
  assign m.m_address = addr_q;
  assign m.m_rw      = rw_q;
  assign m.m_data_in = wd_q;
  assign m.m_enable  = en_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter with a behavioural I2C master.
module tb_i2c_master_arbiter;
  localparam int N  = 4;
  localparam int AW = 7;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_rw;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    grant, done;
  logic            err, busy;
  logic [DW-1:0]   rdata;

  i2c_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

  i2c_master_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_rw    (req_rw),
    .req_wdata (req_wdata),
    .grant     (grant),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .m         (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] rd;
    logic       er;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       me;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_rd;

  function automatic logic [7:0] slave_byte(input logic [6:0] a);
    return {1'b0, a} ^ 8'h6C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, want);
    end
  endtask

  // Master model: drops ready 3 cycles after enable, returns 40 later.
  bit         stuck = 1'b0;
  bit         mbusy = 1'b0;
  int         mcnt  = 0;
  logic [6:0] maddr;

  always @(negedge clk) begin
    if (rst) begin
      mif.m_ready = 1'b1;
      mbusy       = 1'b0;
      mcnt        = 0;
    end else if (!mbusy) begin
      if (mif.m_enable && !stuck) begin
        mbusy = 1'b1;
        mcnt  = 0;
        maddr = mif.m_address;
      end
    end else begin
      mcnt++;
      if (mcnt == 3) mif.m_ready = 1'b0;
      if (mcnt == 43) begin
        mif.m_data_out = slave_byte(maddr);
        mif.m_ready    = 1'b1;
        mbusy          = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every done pulse.
  int low_len   = 0;
  bit in_cont   = 1'b0;
  bit gap_armed = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      if (|done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          me = exp_q.pop_front();
          chk("done_owner", 32'(done), 32'd1 << me.idx);
          chk("grant_at_done", 32'(grant), 32'd1 << me.idx);
          chk("rdata", 32'(rdata), 32'(me.rd));
          chk("err", 32'(err), 32'(me.er));
        end
        if (in_cont) gap_armed = 1'b1;
      end
      if (!busy) low_len++;
      else begin
        if (low_len > 0 && gap_armed && in_cont)
          chk("busy_gap", 32'(low_len), 32'd1);
        low_len = 0;
      end
      if (!in_cont) gap_armed = 1'b0;
    end
  end

  task automatic set_client(input int i, input logic [6:0] a,
                            input logic rw, input logic [7:0] wd);
    req_addr[i*AW +: AW]  = a;
    req_rw[i]             = rw;
    req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic expect_txn(input int i, input logic er);
    exp_t e;
    if (req_rw[i] && !er) last_rd = slave_byte(req_addr[i*AW +: AW]);
    e.idx = i;
    e.rd  = last_rd;
    e.er  = er;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int i, input int max);
    int n;
    n = 0;
    while (n < max) begin
      @(negedge clk);
      n++;
      if (done[i]) break;
    end
    chk($sformatf("done_seen_%0d", i), 32'(done[i]), 32'd1);
    req[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    exp_q.delete();
    last_rd = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    rst       = 1'b1;
    req       = '0;
    req_addr  = '0;
    req_rw    = '0;
    req_wdata = '0;
    last_rd   = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_enable", 32'(mif.m_enable), 32'd0);
    chk("rst_address", 32'(mif.m_address), 32'd0);

    // Single write from client 0
    set_client(0, 7'h50, 1'b0, 8'hA5);
    expect_txn(0, 1'b0);
    req[0] = 1'b1;
    @(posedge clk); #1;
    chk("lat1_enable", 32'(mif.m_enable), 32'd0);
    chk("w_grant", 32'(grant), 32'b0001);
    chk("w_address", 32'(mif.m_address), 32'h50);
    chk("w_data_in", 32'(mif.m_data_in), 32'hA5);
    chk("w_rw", 32'(mif.m_rw), 32'd0);
    chk("w_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("lat2_enable", 32'(mif.m_enable), 32'd1);
    req_addr[0 +: AW] = 7'h51;
    wait_done(0, 200);
    chk("addr_latched", 32'(mif.m_address), 32'h50);

    // Single read from client 2, req dropped mid-transaction
    set_client(2, 7'h50, 1'b1, 8'h00);
    expect_txn(2, 1'b0);
    req[2] = 1'b1;
    repeat (3) @(negedge clk);
    chk("r_grant", 32'(grant), 32'b0100);
    req[2] = 1'b0;
    wait_done(2, 200);
    repeat (3) @(negedge clk);
    chk("rdata_hold", 32'(rdata), 32'h3C);

    // Reset during WAIT_DONE of client 1
    set_client(1, 7'h21, 1'b0, 8'h5A);
    req[1] = 1'b1;
    n = 0;
    while (mif.m_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("ready_dropped", 32'(mif.m_ready), 32'd0);
    repeat (4) @(negedge clk);
    chk("pre_rst_grant", 32'(grant), 32'b0010);
    chk("pre_rst_enable", 32'(mif.m_enable), 32'd0);
    rst = 1'b1;
    #1;
    chk("mrst_grant", 32'(grant), 32'd0);
    chk("mrst_enable", 32'(mif.m_enable), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_rdata", 32'(rdata), 32'd0);
    req = '0;
    exp_q.delete();
    last_rd = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_client(2, 7'h22, 1'b0, 8'h11);
    expect_txn(1, 1'b0);
    expect_txn(2, 1'b0);
    req[1] = 1'b1;
    req[2] = 1'b1;
    wait_done(1, 200);
    wait_done(2, 200);

    // Four-way contention for eight transactions
    do_reset();
    for (int i = 0; i < N; i++)
      set_client(i, 7'(16 + i), i[0], 8'(8'hC0 + i));
    for (int k = 0; k < 8; k++) expect_txn(k % N, 1'b0);
    in_cont = 1'b1;
    req     = 4'b1111;
    seen    = 0;
    n       = 0;
    while (seen < 8 && n < 1000) begin
      @(negedge clk);
      n++;
      if (|done) seen++;
    end
    req     = '0;
    in_cont = 1'b0;
    chk("cont_count", 32'(seen), 32'd8);

`ifdef I2C_MASTER_ARBITER_TIMEOUT_EN
    // Master never leaves ready: abort, then normal service resumes
    stuck = 1'b1;
    set_client(0, 7'h30, 1'b0, 8'h77);
    expect_txn(0, 1'b1);
    req[0] = 1'b1;
    wait_done(0, 300);
    chk("to_enable_low", 32'(mif.m_enable), 32'd0);
    stuck = 1'b0;
    set_client(1, 7'h11, 1'b1, 8'h00);
    expect_txn(1, 1'b0);
    req[1] = 1'b1;
    wait_done(1, 300);
`endif

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
- Shares one i2c_master_controller between NUM_REQ on-chip requesters.
- Performs round-robin arbitration and latches the winner's address/rw/data onto the master command port.
- Runs the master's enable/ready handshake and returns read data plus a per-requester done pulse.
- Sits between system-side clients (sensor pollers, config loaders) and the single I2C master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 7, I2C device address width.
- DATA_WIDTH, 8, data byte width.
- TIMEOUT_CYCLES, 4096, clk cycles allowed per transaction before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock (same clock as master).
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  request level per client; held until own done.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; client i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_rw  in  NUM_REQ  0 = write, 1 = read.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- grant  out  NUM_REQ  one-hot owner, held for the whole transaction.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- err  out  1  valid with done; 1 = aborted by timeout.
- rdata  out  DATA_WIDTH  read byte; valid with done; holds until next done.
- busy  out  1  high in any state other than IDLE.
- m_address  out  ADDR_WIDTH  to master address.
- m_rw  out  1  to master rw.
- m_data_in  out  DATA_WIDTH  to master data_in.
- m_enable  out  1  to master enable.
- m_data_out  in  DATA_WIDTH  from master data_out.
- m_ready  in  1  from master ready.

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; round-robin pointer rr_ptr = NUM_REQ-1 (so client 0 wins first); timeout counter 0.
- m_ready is registered once (m_ready_q, reset value 1) before use. All decisions use m_ready_q.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, COMPLETE.
- IDLE:
  - If any req bit is set and m_ready_q=1, pick the first set bit scanning rr_ptr+1 upward, modulo NUM_REQ.
  - Register grant (one-hot), m_address, m_rw and m_data_in from the winner's slice; set rr_ptr to the winner; go to LAUNCH.
  - If no req bit is set, or m_ready_q=0, stay in IDLE.
- LAUNCH: set m_enable=1; go to WAIT_BUSY.
- WAIT_BUSY:
  - Hold m_enable=1 until m_ready_q=0 (master has left IDLE).
  - Then clear m_enable and go to WAIT_DONE.
  - Dropping enable forces the master to issue STOP after a write.
- WAIT_DONE: on m_ready_q=1, capture rdata <= m_data_out if m_rw=1 (unchanged on write), err=0; go to COMPLETE.
- COMPLETE:
  - done = grant for exactly 1 cycle; then clear grant; return to IDLE.
  - The next arbitration starts one cycle later (no back-to-back in the same cycle).
- Latency: req high in IDLE to m_enable high is 2 clk cycles.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 transactions.
- Boundary conditions:
  - Requester drops req mid-transaction: ignored; the transaction completes and done still pulses.
  - Payload changes after grant: ignored, because the payload is latched in IDLE.
  - Multiple requests in the same cycle: round-robin order applies; the winner's req stays set for the next round.
  - Address ACK failure (master goes to STOP then IDLE): indistinguishable from success; done pulses and err=0. NACK reporting is not supported.
  - rst asserted mid-transaction: immediate return to IDLE with outputs cleared. The master is reset by the same rst, so there is no stranded bus.
  - NUM_REQ=1: grant is constant-priority; rr_ptr logic degenerates correctly.

Optional Feature:
- Macro: I2C_MASTER_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter clears in LAUNCH and increments each cycle in WAIT_BUSY/WAIT_DONE.
  - On reaching TIMEOUT_CYCLES-1: clear m_enable, rdata unchanged, err=1 with the done pulse, go to COMPLETE.
- Undefined: no counter is built; err is tied 0; WAIT_BUSY and WAIT_DONE wait indefinitely.

Decomposition:
- Package i2c_arb_pkg:
  - arb_state_t enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, COMPLETE).
  - Localparam helper for rr_ptr width ($clog2 of NUM_REQ, min 1).
- One sub-module, i2c_rr_picker: purely combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot winner and its index.
  - Reusable by other shared-bus arbiters.

Test Plan:
- Single write: req[0]=1, addr 0x50, rw=0, wdata 0xA5; bench master model drops ready 3 cycles after enable and restores it 40 cycles later -> m_enable high at cycle 2; grant=0001 throughout; done[0] pulses once; err=0; rdata unchanged.
- Single read: req[2]=1, rw=1; master returns m_data_out=0x3C -> rdata=0x3C when done[2] pulses.
- Contention: req=1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3; no grant overlap; busy low for exactly 1 cycle between transactions.
- Mid-transaction reset: assert rst during WAIT_DONE -> grant, m_enable, busy, done all 0 same cycle; after release, req[1] is served first (pointer reset).
- Payload stability: change req_addr[0] from 0x50 to 0x51 after grant -> m_address stays 0x50 until done.
- Timeout (I2C_MASTER_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=64): m_ready held high forever -> m_enable drops; done pulses with err=1; the next requester is then granted normally.
